// File: rtl/core_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : core_wb_bridge
//  Description : Core request/grant/rvalid port to Wishbone B4 pipelined
//                master. Requests pass straight through; a small in-order
//                FIFO remembers read/write type of each in-flight transfer
//                so responses can be classified and returned one cycle
//                after ack/err.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_wb_bridge #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    // core side
    input  logic        core_req,
    output logic        core_gnt,
    output logic        core_rvalid,
    input  logic        core_we,
    input  logic [3:0]  core_be,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_err,
    // wishbone side
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic        wb_stall
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // outstanding-transfer count and in-order type FIFO (bit 0 is the head)
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [CNT_W-1:0]           wr_idx;

    // registered response stage
    logic        rvalid_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic full;
    logic acc;
    logic rsp;
    logic head_we;

    assign full     = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign wb_stb   = core_req & ~full;
    assign core_gnt = wb_stb & ~wb_stall;
    assign acc      = core_gnt;
    // acks with nothing outstanding are spurious and must not touch state
    assign rsp      = (wb_ack | wb_err) & (cnt_q != '0);
    assign head_we  = fifo_q[0];

    // request attributes go to the bus unregistered so grant stays same-cycle
    assign wb_cyc   = wb_stb | (cnt_q != '0);
    assign wb_we    = core_we;
    assign wb_sel   = core_be;
    assign wb_adr   = core_addr;
    assign wb_dat_o = core_wdata;

    assign core_rvalid = rvalid_q;
    assign core_err    = err_q;
    assign core_rdata  = rdata_q;

    // next count and FIFO contents: pop shifts the FIFO down, push lands at the tail
    always_comb begin
        fifo_d = fifo_q;
        wr_idx = cnt_q;
        if (rsp) begin
            fifo_d = fifo_q >> 1;
            wr_idx = cnt_q - CNT_W'(1);
        end
        if (acc) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    fifo_d[i] = core_we;
                end
            end
        end
        cnt_d = cnt_q + CNT_W'(acc) - CNT_W'(rsp);
    end

    // tracking state; reset discards everything in flight at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            fifo_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            fifo_q <= fifo_d;
        end
    end

    // response stage: data/err only update on a response, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            rvalid_q <= rsp;
            if (rsp) begin
                err_q   <= wb_err;
                rdata_q <= (!head_we && !wb_err) ? wb_dat_i : 32'h0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_wb_bridge
//  Description : Self-checking bench for core_wb_bridge: directed scenarios
//                followed by random traffic, checked against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_wb_bridge;

    localparam int MAX = 2;

    logic        clk;
    logic        rst_n;
    logic        core_req;
    logic        core_gnt;
    logic        core_rvalid;
    logic        core_we;
    logic [3:0]  core_be;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_stall;

    int n_checks;
    int n_errors;

    // reference model: queue of write flags for accepted, unanswered transfers
    bit          model_q[$];
    logic        exp_rvalid;
    logic        exp_err;
    logic [31:0] exp_rdata;

    core_wb_bridge #(.MAX_OUTSTANDING(MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_req    (core_req),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_we     (core_we),
        .core_be     (core_be),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .core_err    (core_err),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_sel      (wb_sel),
        .wb_adr      (wb_adr),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack      (wb_ack),
        .wb_err      (wb_err),
        .wb_stall    (wb_stall)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic ack, input logic err, input logic stall,
                         input logic [31:0] dat);
        core_req   = req;
        core_we    = we;
        core_be    = be;
        core_addr  = addr;
        core_wdata = wdata;
        wb_ack     = ack;
        wb_err     = err;
        wb_stall   = stall;
        wb_dat_i   = dat;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // one clock: check request-side outputs, advance model, check response stage
    task automatic step();
        bit e_full, e_stb, e_gnt, e_cyc, e_rsp, w;
        #1;
        e_full = (model_q.size() == MAX);
        e_stb  = core_req && !e_full;
        e_gnt  = e_stb && !wb_stall;
        e_cyc  = e_stb || (model_q.size() != 0);
        check_val("wb_stb",   wb_stb,   e_stb);
        check_val("core_gnt", core_gnt, e_gnt);
        check_val("wb_cyc",   wb_cyc,   e_cyc);
        check_val("wb_we",    wb_we,    core_we);
        check_val("wb_sel",   wb_sel,   core_be);
        check_val("wb_adr",   wb_adr,   core_addr);
        check_val("wb_dat_o", wb_dat_o, core_wdata);
        e_rsp = rst_n && (wb_ack || wb_err) && (model_q.size() != 0);
        if (e_rsp) begin
            w          = model_q.pop_front();
            exp_rvalid = 1'b1;
            exp_err    = wb_err;
            exp_rdata  = (!w && !wb_err) ? wb_dat_i : 32'h0;
        end else begin
            exp_rvalid = 1'b0;
        end
        if (e_gnt && rst_n) model_q.push_back(core_we);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_q.delete();
            exp_rvalid = 1'b0;
            exp_err    = 1'b0;
            exp_rdata  = 32'h0;
        end
        check_val("core_rvalid", core_rvalid, exp_rvalid);
        check_val("core_err",    core_err,    exp_err);
        check_val("core_rdata",  core_rdata,  exp_rdata);
    endtask

    task automatic read_req(input logic [31:0] addr);
        drive(1'b1, 1'b0, 4'hF, addr, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
    endtask

    task automatic ack_only(input logic ack, input logic err, input logic [31:0] dat);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ack, err, 1'b0, dat);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        n_checks   = 0;
        n_errors   = 0;
        clk        = 1'b0;
        rst_n      = 1'b0;
        exp_rvalid = 1'b0;
        exp_err    = 1'b0;
        exp_rdata  = 32'h0;
        idle();

        // reset state
        step();
        step();
        rst_n = 1'b1;
        idle();
        step();

        // single read
        read_req(32'h0000_1000);
        ack_only(1'b1, 1'b0, 32'hDEAD_BEEF);
        idle();
        step();

        // stalled writes, then both granted back to back
        repeat (3) begin
            drive(1'b1, 1'b1, 4'b0011, 32'h2000, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 32'h0);
            step();
        end
        drive(1'b1, 1'b1, 4'b0011, 32'h2000, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b1, 4'b1100, 32'h2004, 32'hA5A5_0002, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        ack_only(1'b1, 1'b0, 32'hFFFF_FFFF);
        ack_only(1'b1, 1'b0, 32'h1234_5678);
        idle();
        step();

        // outstanding limit: third read waits for room
        read_req(32'h3000);
        read_req(32'h3004);
        read_req(32'h3008);
        read_req(32'h3008);
        drive(1'b1, 1'b0, 4'hF, 32'h3008, 32'h0, 1'b1, 1'b0, 1'b0, 32'h11);
        step();
        drive(1'b1, 1'b0, 4'hF, 32'h3008, 32'h0, 1'b1, 1'b0, 1'b0, 32'h22);
        step();
        ack_only(1'b1, 1'b0, 32'h33);
        idle();
        step();

        // error responses: err alone, then ack and err together
        read_req(32'h4000);
        ack_only(1'b0, 1'b1, 32'hCAFE_0001);
        read_req(32'h4004);
        ack_only(1'b1, 1'b1, 32'hCAFE_0002);
        idle();
        step();

        // accept overlapping a response, write classified ahead of read
        drive(1'b1, 1'b1, 4'hF, 32'h5000, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 4'hF, 32'h5004, 32'h0, 1'b1, 1'b0, 1'b0, 32'h99);
        step();
        drive(1'b1, 1'b0, 4'hF, 32'h5008, 32'h0, 1'b1, 1'b0, 1'b0, 32'h88);
        step();
        ack_only(1'b1, 1'b0, 32'h77);
        // spurious ack with nothing outstanding
        ack_only(1'b1, 1'b0, 32'h66);
        ack_only(1'b0, 1'b1, 32'h65);
        idle();
        step();

        // reset with two reads in flight
        read_req(32'h6000);
        read_req(32'h6004);
        idle();
        rst_n = 1'b0;
        model_q.delete();
        exp_rvalid = 1'b0;
        exp_err    = 1'b0;
        exp_rdata  = 32'h0;
        #1;
        check_val("rst_async_cyc",    wb_cyc,      1'b0);
        check_val("rst_async_rvalid", core_rvalid, 1'b0);
        step();
        rst_n = 1'b1;
        ack_only(1'b1, 1'b0, 32'h5151_5151);
        read_req(32'h7000);
        ack_only(1'b1, 1'b0, 32'h7777_0000);
        idle();
        step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 7);
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 4'($urandom),
                  $urandom, $urandom,
                  (r <= 3) || (r == 5), (r == 4) || (r == 5),
                  ($urandom_range(0, 3) == 0), $urandom);
            step();
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
